// File: rtl/trap_ctrl_pkg.sv
// Shared constants, state encoding and cause values for the trap entry/exit sequencer.
package trap_ctrl_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned CSR_AW   = 12;

    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [63:0] ECALL_CAUSE_M = 64'd11;
    localparam logic [63:0] TIMER_CAUSE_M = 64'h8000_0000_0000_0007;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_W_EPC    = 3'd1,
        ST_W_CAUSE  = 3'd2,
        ST_W_STATUS = 3'd3,
        ST_REDIRECT = 3'd4
    } state_t;

endpackage

// File: rtl/trap_status_calc.sv
// Combinational mstatus transform for trap entry (exit_trap=0) and mret (exit_trap=1).
module trap_status_calc
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] mstatus,
    input  logic            exit_trap,
    output logic [XLEN-1:0] status_nxt_c
);

    always_comb begin
        status_nxt_c = mstatus;
        status_nxt_c[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        if (exit_trap) begin
            status_nxt_c[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
            status_nxt_c[MSTATUS_MPIE] = 1'b1;
        end else begin
            status_nxt_c[MSTATUS_MPIE] = mstatus[MSTATUS_MIE];
            status_nxt_c[MSTATUS_MIE]  = 1'b0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap entry/exit sequencer: ecall, mret and machine timer interrupt at the WB boundary.
// Writes mepc/mcause/mstatus on consecutive cycles, then flushes and redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN        = XLEN_DEF,
    parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(ECALL_CAUSE_M),
    parameter logic [XLEN-1:0] TIMER_CAUSE = XLEN'(TIMER_CAUSE_M)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    input  logic [XLEN-1:0]   wb_pc,
    input  logic [XLEN-1:0]   wb_npc,
    input  logic              wb_ecall,
    input  logic              wb_mret,
    input  logic              ls_busy,
    input  logic              timer_irq,
    input  logic [XLEN-1:0]   mstatus_i,
    input  logic              mie_mtie,
    input  logic [XLEN-1:0]   mtvec_i,
    input  logic [XLEN-1:0]   mepc_i,
    output logic              csr_we,
    output logic [CSR_AW-1:0] csr_waddr,
    output logic [XLEN-1:0]   csr_wdata,
    output logic              flush,
    output logic              hold,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic              irq_taken
);

    state_t            state_q, state_d;
    logic [XLEN-1:0]   epc_q, epc_d;
    logic [XLEN-1:0]   cause_q, cause_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              mret_q, mret_d;
    logic              irq_pend;
    logic [XLEN-1:0]   status_nxt_c;

    logic              csr_we_d;
    logic [CSR_AW-1:0] csr_waddr_d;
    logic [XLEN-1:0]   csr_wdata_d;
    logic              flush_d;
    logic              hold_d;
    logic              redirect_valid_d;
    logic [XLEN-1:0]   redirect_pc_d;
    logic              irq_taken_d;

    assign irq_pend = timer_irq & mstatus_i[MSTATUS_MIE] & mie_mtie;

    trap_status_calc #(
        .XLEN (XLEN)
    ) u_status_calc (
        .mstatus      (mstatus_i),
        .exit_trap    (mret_d),
        .status_nxt_c (status_nxt_c)
    );

    // Next state and latches, then outputs decoded from the next state so they leave a flop.
    always_comb begin
        state_d          = state_q;
        epc_d            = epc_q;
        cause_d          = cause_q;
        target_d         = target_q;
        mret_d           = mret_q;
        irq_taken_d      = 1'b0;
        csr_we_d         = 1'b0;
        csr_waddr_d      = '0;
        csr_wdata_d      = '0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;

        case (state_q)
            ST_IDLE: begin
                // Synchronous events outrank the interrupt; the interrupt is retried once back in IDLE.
                if (wb_valid && wb_ecall) begin
                    epc_d    = wb_pc;
                    cause_d  = ECALL_CAUSE;
                    target_d = mtvec_i;
                    mret_d   = 1'b0;
                    state_d  = ST_W_EPC;
                end else if (wb_valid && wb_mret) begin
                    target_d = mepc_i;
                    mret_d   = 1'b1;
                    state_d  = ST_W_STATUS;
                end else if (wb_valid && irq_pend && !ls_busy) begin
                    epc_d       = wb_npc;
                    cause_d     = TIMER_CAUSE;
                    target_d    = mtvec_i;
                    mret_d      = 1'b0;
                    irq_taken_d = 1'b1;
                    state_d     = ST_W_EPC;
                end
            end
            ST_W_EPC:    state_d = ST_W_CAUSE;
            ST_W_CAUSE:  state_d = ST_W_STATUS;
            ST_W_STATUS: state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        hold_d = (state_d != ST_IDLE);

        case (state_d)
            ST_W_EPC: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MEPC;
                csr_wdata_d = epc_d;
                flush_d     = 1'b1;
            end
            ST_W_CAUSE: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MCAUSE;
                csr_wdata_d = cause_d;
            end
            ST_W_STATUS: begin
                csr_we_d    = 1'b1;
                csr_waddr_d = CSR_MSTATUS;
                csr_wdata_d = status_nxt_c;
                flush_d     = mret_d;
            end
            ST_REDIRECT: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = target_d;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            epc_q          <= '0;
            cause_q        <= '0;
            target_q       <= '0;
            mret_q         <= 1'b0;
            csr_we         <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            flush          <= 1'b0;
            hold           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            irq_taken      <= 1'b0;
        end else begin
            state_q        <= state_d;
            epc_q          <= epc_d;
            cause_q        <= cause_d;
            target_q       <= target_d;
            mret_q         <= mret_d;
            csr_we         <= csr_we_d;
            csr_waddr      <= csr_waddr_d;
            csr_wdata      <= csr_wdata_d;
            flush          <= flush_d;
            hold           <= hold_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            irq_taken      <= irq_taken_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traffic against a transaction model.
module tb_trap_ctrl;

    typedef struct packed {
        logic        we;
        logic [11:0] addr;
        logic [63:0] data;
        logic        flush;
        logic        hold;
        logic        rv;
        logic [63:0] rpc;
        logic        irq;
    } out_t;

    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [63:0] wb_npc;
    logic        wb_ecall;
    logic        wb_mret;
    logic        ls_busy;
    logic        timer_irq;
    logic [63:0] mstatus_i;
    logic        mie_mtie;
    logic [63:0] mtvec_i;
    logic [63:0] mepc_i;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [63:0] csr_wdata;
    logic        flush;
    logic        hold;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        irq_taken;

    int   n_pass  = 0;
    int   n_total = 0;
    out_t exp_q[$];

    trap_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_pc          (wb_pc),
        .wb_npc         (wb_npc),
        .wb_ecall       (wb_ecall),
        .wb_mret        (wb_mret),
        .ls_busy        (ls_busy),
        .timer_irq      (timer_irq),
        .mstatus_i      (mstatus_i),
        .mie_mtie       (mie_mtie),
        .mtvec_i        (mtvec_i),
        .mepc_i         (mepc_i),
        .csr_we         (csr_we),
        .csr_waddr      (csr_waddr),
        .csr_wdata      (csr_wdata),
        .flush          (flush),
        .hold           (hold),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .irq_taken      (irq_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid  = 1'b0;
        wb_ecall  = 1'b0;
        wb_mret   = 1'b0;
        ls_busy   = 1'b0;
        timer_irq = 1'b0;
        mie_mtie  = 1'b0;
        wb_pc     = 64'h0;
        wb_npc    = 64'h0;
    endtask

    function automatic out_t outs();
        out_t o;
        o.we    = csr_we;
        o.addr  = csr_waddr;
        o.data  = csr_wdata;
        o.flush = flush;
        o.hold  = hold;
        o.rv    = redirect_valid;
        o.rpc   = redirect_pc;
        o.irq   = irq_taken;
        return o;
    endfunction

    // Every non-idle cycle of a sequence holds the pipeline.
    function automatic out_t mk(logic we, logic [11:0] a, logic [63:0] d, logic fl,
                                logic rv, logic [63:0] rpc, logic irq);
        out_t o;
        o.we = we; o.addr = a; o.data = d; o.flush = fl;
        o.hold = 1'b1; o.rv = rv; o.rpc = rpc; o.irq = irq;
        return o;
    endfunction

    // Reference: the list of output cycles that an IDLE-cycle input set must produce.
    function automatic void model_event();
        logic        pend;
        logic [63:0] ent;
        logic [63:0] ext;
        pend = timer_irq && mstatus_i[3] && mie_mtie;
        ent  = (mstatus_i & ~64'h1888) | 64'h1800 | (mstatus_i[3] ? 64'h80 : 64'h0);
        ext  = (mstatus_i & ~64'h1888) | 64'h1880 | (mstatus_i[7] ? 64'h8 : 64'h0);
        if (wb_valid && wb_ecall) begin
            exp_q.push_back(mk(1'b1, 12'h341, wb_pc, 1'b1, 1'b0, 64'h0, 1'b0));
            exp_q.push_back(mk(1'b1, 12'h342, 64'd11, 1'b0, 1'b0, 64'h0, 1'b0));
            exp_q.push_back(mk(1'b1, 12'h300, ent, 1'b0, 1'b0, 64'h0, 1'b0));
            exp_q.push_back(mk(1'b0, 12'h0, 64'h0, 1'b0, 1'b1, mtvec_i, 1'b0));
        end else if (wb_valid && wb_mret) begin
            exp_q.push_back(mk(1'b1, 12'h300, ext, 1'b1, 1'b0, 64'h0, 1'b0));
            exp_q.push_back(mk(1'b0, 12'h0, 64'h0, 1'b0, 1'b1, mepc_i, 1'b0));
        end else if (wb_valid && pend && !ls_busy) begin
            exp_q.push_back(mk(1'b1, 12'h341, wb_npc, 1'b1, 1'b0, 64'h0, 1'b1));
            exp_q.push_back(mk(1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b0, 1'b0, 64'h0, 1'b0));
            exp_q.push_back(mk(1'b1, 12'h300, ent, 1'b0, 1'b0, 64'h0, 1'b0));
            exp_q.push_back(mk(1'b0, 12'h0, 64'h0, 1'b0, 1'b1, mtvec_i, 1'b0));
        end
    endfunction

    task automatic test_reset();
        out_t got;
        repeat (2) @(posedge clk);
        #1;
        got = outs();
        n_total++;
        if (got !== '0) $display("FAIL reset_hold got=%h exp=0", got);
        else n_pass++;
        rst = 1'b0;
        tick();
        got = outs();
        n_total++;
        if (got !== '0) $display("FAIL reset_release got=%h exp=0", got);
        else n_pass++;
    endtask

    task automatic test_ecall();
        out_t got;
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 12'h341, 64'h8000_0010, 1'b1, 1'b0, 64'h0, 1'b0));
        exp_q.push_back(mk(1'b1, 12'h342, 64'd11, 1'b0, 1'b0, 64'h0, 1'b0));
        exp_q.push_back(mk(1'b1, 12'h300, 64'h1880, 1'b0, 1'b0, 64'h0, 1'b0));
        exp_q.push_back(mk(1'b0, 12'h0, 64'h0, 1'b0, 1'b1, 64'h8000_0100, 1'b0));
        exp_q.push_back('0);
        idle_inputs();
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0100;
        wb_valid  = 1'b1;
        wb_ecall  = 1'b1;
        wb_pc     = 64'h8000_0010;
        wb_npc    = 64'h8000_0014;
        tick();
        idle_inputs();
        foreach (exp_q[i]) begin
            got = outs();
            n_total++;
            if (got !== exp_q[i]) $display("FAIL ecall_t%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_mret();
        out_t got;
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 12'h300, 64'h1888, 1'b1, 1'b0, 64'h0, 1'b0));
        exp_q.push_back(mk(1'b0, 12'h0, 64'h0, 1'b0, 1'b1, 64'h8000_0014, 1'b0));
        exp_q.push_back('0);
        idle_inputs();
        mstatus_i = 64'h80;
        mepc_i    = 64'h8000_0014;
        wb_valid  = 1'b1;
        wb_mret   = 1'b1;
        tick();
        idle_inputs();
        foreach (exp_q[i]) begin
            got = outs();
            n_total++;
            if (got !== exp_q[i]) $display("FAIL mret_t%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_timer();
        out_t got;
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 12'h341, 64'h8000_0024, 1'b1, 1'b0, 64'h0, 1'b1));
        exp_q.push_back(mk(1'b1, 12'h342, 64'h8000_0000_0000_0007, 1'b0, 1'b0, 64'h0, 1'b0));
        exp_q.push_back(mk(1'b1, 12'h300, 64'h1880, 1'b0, 1'b0, 64'h0, 1'b0));
        exp_q.push_back(mk(1'b0, 12'h0, 64'h0, 1'b0, 1'b1, 64'h8000_0100, 1'b0));
        idle_inputs();
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0100;
        mie_mtie  = 1'b1;
        timer_irq = 1'b1;
        wb_valid  = 1'b1;
        wb_pc     = 64'h8000_0020;
        wb_npc    = 64'h8000_0024;
        tick();
        wb_valid = 1'b0;
        foreach (exp_q[i]) begin
            got = outs();
            n_total++;
            if (got !== exp_q[i]) $display("FAIL timer_t%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            else n_pass++;
            tick();
        end
        // Handler running with MIE cleared: a level timer must not re-enter.
        mstatus_i = 64'h1880;
        wb_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            got = outs();
            n_total++;
            if (got !== '0) $display("FAIL timer_no_retake%0d got=%h exp=0", k, got);
            else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_gating();
        out_t got;
        idle_inputs();
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0200;
        mie_mtie  = 1'b1;
        timer_irq = 1'b1;
        wb_valid  = 1'b1;
        wb_pc     = 64'h8000_003c;
        wb_npc    = 64'h8000_0040;
        ls_busy   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            got = outs();
            n_total++;
            if (got !== '0) $display("FAIL gating_busy%0d got=%h exp=0", k, got);
            else n_pass++;
        end
        ls_busy  = 1'b0;
        wb_valid = 1'b0;
        tick();
        got = outs();
        n_total++;
        if (got !== '0) $display("FAIL gating_noretire got=%h exp=0", got);
        else n_pass++;
        wb_valid = 1'b1;
        exp_q.delete();
        model_event();
        exp_q.push_back('0);
        tick();
        wb_valid = 1'b0;
        foreach (exp_q[i]) begin
            got = outs();
            n_total++;
            if (got !== exp_q[i]) $display("FAIL gating_take_t%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            else n_pass++;
            tick();
        end
        mstatus_i = 64'h0;
        wb_valid  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            got = outs();
            n_total++;
            if (got !== '0) $display("FAIL gating_mie0_%0d got=%h exp=0", k, got);
            else n_pass++;
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_collision();
        out_t got;
        idle_inputs();
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0300;
        mie_mtie  = 1'b1;
        timer_irq = 1'b1;
        wb_valid  = 1'b1;
        wb_ecall  = 1'b1;
        wb_pc     = 64'h8000_0060;
        wb_npc    = 64'h8000_0064;
        exp_q.delete();
        model_event();
        tick();
        wb_valid = 1'b0;
        wb_ecall = 1'b0;
        foreach (exp_q[i]) begin
            got = outs();
            n_total++;
            if (got !== exp_q[i]) $display("FAIL collide_ecall_t%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            else n_pass++;
            tick();
        end
        wb_valid = 1'b1;
        wb_pc    = 64'h8000_0300;
        wb_npc   = 64'h8000_0304;
        exp_q.delete();
        model_event();
        exp_q.push_back('0);
        tick();
        idle_inputs();
        foreach (exp_q[i]) begin
            got = outs();
            n_total++;
            if (got !== exp_q[i]) $display("FAIL collide_timer_t%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        out_t got;
        idle_inputs();
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0400;
        wb_valid  = 1'b1;
        wb_ecall  = 1'b1;
        wb_pc     = 64'h8000_0070;
        exp_q.delete();
        model_event();
        tick();
        idle_inputs();
        foreach (exp_q[i]) begin
            got = outs();
            n_total++;
            if (got !== exp_q[i]) $display("FAIL b2b_ecall_t%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            else n_pass++;
            tick();
        end
        // First IDLE cycle after the redirect accepts the mret.
        mstatus_i = 64'h1880;
        mepc_i    = 64'h8000_0074;
        wb_valid  = 1'b1;
        wb_mret   = 1'b1;
        exp_q.delete();
        model_event();
        exp_q.push_back('0);
        tick();
        idle_inputs();
        foreach (exp_q[i]) begin
            got = outs();
            n_total++;
            if (got !== exp_q[i]) $display("FAIL b2b_mret_t%0d got=%h exp=%h", i + 1, got, exp_q[i]);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        out_t got;
        idle_inputs();
        mstatus_i = 64'h8;
        mtvec_i   = 64'h8000_0500;
        wb_valid  = 1'b1;
        wb_ecall  = 1'b1;
        wb_pc     = 64'h8000_0080;
        tick();
        idle_inputs();
        tick();
        got = outs();
        n_total++;
        if (!(got.we === 1'b1 && got.addr === 12'h342))
            $display("FAIL rstmid_pre we=%b addr=%h exp we=1 addr=342", got.we, got.addr);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        got = outs();
        n_total++;
        if (got !== '0) $display("FAIL rstmid_async got=%h exp=0", got);
        else n_pass++;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            got = outs();
            n_total++;
            if (got !== '0) $display("FAIL rstmid_after%0d got=%h exp=0", k, got);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        out_t        got;
        out_t        exp;
        logic [63:0] ms;
        logic [63:0] mep;
        ms  = 64'h8;
        mep = 64'h0;
        exp_q.delete();
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            got = outs();
            if (exp_q.size() != 0) exp = exp_q.pop_front();
            else exp = '0;
            n_total++;
            if (got !== exp) $display("FAIL random_c%0d got=%h exp=%h", c, got, exp);
            else n_pass++;
            if (!exp.hold && $urandom_range(9) == 0) ms = {$urandom, $urandom};
            wb_valid  = ($urandom_range(9) < 7);
            wb_ecall  = ($urandom_range(99) < 15);
            wb_mret   = ($urandom_range(99) < 15);
            ls_busy   = ($urandom_range(9) < 3);
            timer_irq = ($urandom_range(9) < 4);
            mie_mtie  = ($urandom_range(9) < 8);
            wb_pc     = {$urandom, $urandom};
            wb_npc    = {$urandom, $urandom};
            mtvec_i   = {$urandom, $urandom};
            mstatus_i = ms;
            mepc_i    = mep;
            if (!exp.hold) model_event();
            // CSR file commits the expected writes at the end of this cycle.
            if (exp.we && exp.addr == 12'h300) ms = exp.data;
            if (exp.we && exp.addr == 12'h341) mep = exp.data;
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        rst       = 1'b1;
        mstatus_i = 64'h0;
        mtvec_i   = 64'h0;
        mepc_i    = 64'h0;
        idle_inputs();
        test_reset();
        test_ecall();
        test_mret();
        test_timer();
        test_gating();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequences trap entry and exit at the write-back boundary: ecall, mret, and the machine timer interrupt.
- Drives the CSR write port (mepc, mcause, mstatus) over fixed consecutive cycles, then issues one flush-and-redirect to the fetch stage.
- Sits beside the write-back unit. Takes retire information from WB and CSR read values from the CSR file; drives the CSR write port, pipeline flush, fetch redirect and a global hold.

Parameters:
- XLEN, 64, data/PC width
- ECALL_CAUSE, 64'd11, mcause value for ecall from M-mode
- TIMER_CAUSE, 64'h8000000000000007, mcause value for machine timer interrupt

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wb_valid  in  1  an instruction retires in WB this cycle
- wb_pc  in  XLEN  PC of retiring instruction
- wb_npc  in  XLEN  architectural next PC of retiring instruction
- wb_ecall  in  1  retiring instruction is ecall (qualified by wb_valid)
- wb_mret  in  1  retiring instruction is mret (qualified by wb_valid)
- ls_busy  in  1  memory transaction outstanding; interrupt must not be taken
- timer_irq  in  1  level timer interrupt from CLINT
- mstatus_i  in  XLEN  current mstatus
- mie_mtie  in  1  mie.MTIE
- mtvec_i  in  XLEN  current mtvec
- mepc_i  in  XLEN  current mepc
- csr_we  out  1  CSR write strobe
- csr_waddr  out  12  CSR address
- csr_wdata  out  XLEN  CSR write data
- flush  out  1  squash all younger in-flight instructions
- hold  out  1  freeze fetch/decode while sequencing
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  XLEN  redirect target
- irq_taken  out  1  one-cycle pulse when an interrupt is accepted

Behaviour:
- Reset: state IDLE; every output 0; latched epc/cause/target registers 0. Reset mid-sequence aborts the sequence; no CSR write is completed afterwards.
- States: IDLE, W_EPC, W_CAUSE, W_STATUS, REDIRECT.
- Interrupt pending: irq_pend = timer_irq & mstatus_i[3] & mie_mtie.
- IDLE, priority order on cycle T:
  1. wb_valid & wb_ecall: latch epc = wb_pc, cause = ECALL_CAUSE, target = mtvec_i; go to W_EPC.
  2. wb_valid & wb_mret: latch target = mepc_i; go to W_STATUS (mret path).
  3. wb_valid & irq_pend & ~ls_busy: latch epc = wb_npc, cause = TIMER_CAUSE, target = mtvec_i; irq_taken = 1 for cycle T+1; go to W_EPC.
  4. Otherwise stay in IDLE.
- Interrupt coinciding with ecall or mret: the synchronous event wins. The interrupt is re-evaluated after return to IDLE.
- W_EPC (T+1): csr_we = 1, waddr = 0x341, wdata = epc; flush = 1 for this cycle only; go to W_CAUSE.
- W_CAUSE (T+2): csr_we = 1, waddr = 0x342, wdata = cause; go to W_STATUS.
- W_STATUS, trap path: csr_we = 1, waddr = 0x300, wdata = mstatus_i with MPIE(bit 7) = MIE(bit 3), MIE = 0, MPP[12:11] = 2'b11.
- W_STATUS, mret path: wdata = mstatus_i with MIE = MPIE, MPIE = 1, MPP = 2'b11.
- Mret path flush: asserted in the W_STATUS cycle, which is the first post-IDLE cycle.
- REDIRECT: redirect_valid = 1, redirect_pc = target; go to IDLE next cycle.
- hold = 1 in every non-IDLE state.
- All outputs are registered/state-decoded; none depend combinationally on wb_* inputs.
- Latency: trap = redirect at T+4, IDLE at T+5; mret = redirect at T+2.
- In non-IDLE states all wb_*, timer_irq and ls_busy inputs are ignored.
- timer_irq dropping mid-sequence does not alter the sequence (cause already latched).
- Timer staying high after entry is not re-taken, because MIE is cleared by the W_STATUS write.
- Back-to-back: IDLE can accept a new event in the same cycle it is re-entered.

Decomposition:
- Shared package/define file:
  - CSR addresses: MEPC 0x341, MCAUSE 0x342, MSTATUS 0x300.
  - mstatus bit indices: MIE 3, MPIE 7, MPP 12:11.
  - State encoding localparams.
  - Cause constants.
- Sub-module trap_status_calc: purely combinational mstatus entry/exit transform. Everything else stays in one module.

Test Plan:
- ecall: wb_valid=1, wb_ecall=1, wb_pc=0x80000010, mtvec_i=0x80000100 -> csr writes 0x341/0x80000010, 0x342/11, 0x300 in consecutive cycles; flush at T+1; redirect_pc=0x80000100 at T+4; hold high T+1..T+4.
- mret: mepc_i=0x80000014, mstatus_i=0x80 -> T+1: write 0x300 with MIE=1, MPIE=1, MPP=3, plus flush; T+2: redirect 0x80000014.
- Timer: timer_irq=1, MIE=1, MTIE=1, wb_npc=0x80000024, ls_busy=0 -> irq_taken at T+1; mcause 0x8000000000000007; mepc 0x80000024.
- Gating: irq pending with ls_busy=1 for 3 cycles -> no action; taken on the first retire after ls_busy falls. With mstatus MIE=0 -> never taken.
- Collision: ecall and pending timer in the same cycle -> cause 11. After return, with the interrupt still pending and MIE=1, the timer trap follows.
- Reset in W_CAUSE: rst pulse -> all outputs 0 immediately; no further csr_we; IDLE after release.
